// File: rtl/axis_pkt_shaper.sv
// axis_pkt_shaper: store-and-forward AXI-Stream packet buffer that releases whole packets
// and limits packets outstanding downstream using returned credits.
module axis_pkt_shaper #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int MAX_PKTS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  input  logic                  pkt_credit_ret,
  output logic [7:0]            pkts_outstanding,
  output logic                  credit_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [7:0] MAXP = 8'(MAX_PKTS);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] occ, complete_pkts;
  logic jumbo, jumbo_in_pending;
  logic s_hs, m_hs, m_eop, inc, dec, ret_ok, can_send, go_jumbo;
  assign s_tready = !rst && occ != FULL;
  assign m_tvalid = !rst && state == SEND && occ != '0;
  assign m_tdata  = rst ? '0 : mem[rd_ptr][DATA_WIDTH-1:0];
  assign m_tlast  = !rst && mem[rd_ptr][DATA_WIDTH];
  assign s_hs     = s_tvalid && s_tready;
  assign m_hs     = m_tvalid && m_tready;
  assign m_eop    = m_hs && m_tlast;
  assign inc      = s_hs && s_tlast && !jumbo_in_pending;
  assign dec      = m_eop && !jumbo;
  assign ret_ok   = pkt_credit_ret && pkts_outstanding != 8'd0;
  // A full buffer with no complete packet can only hold a packet longer than DEPTH: cut it through.
  assign can_send = pkts_outstanding < MAXP && (complete_pkts != '0 || occ == FULL);
  assign go_jumbo = state == IDLE && can_send && complete_pkts == '0;
  always_ff @(posedge clk)
    if (s_hs) mem[wr_ptr] <= {s_tlast, s_tdata};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occ              <= '0;
      complete_pkts    <= '0;
      pkts_outstanding <= 8'd0;
      credit_err       <= 1'b0;
    end else begin
      if (s_hs) wr_ptr <= wr_ptr + 1'b1;
      if (m_hs) rd_ptr <= rd_ptr + 1'b1;
      occ              <= occ + (AW+1)'(s_hs) - (AW+1)'(m_hs);
      complete_pkts    <= complete_pkts + (AW+1)'(inc) - (AW+1)'(dec);
      pkts_outstanding <= pkts_outstanding + 8'(m_eop) - 8'(ret_ok);
      if (pkt_credit_ret && pkts_outstanding == 8'd0) credit_err <= 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state            <= IDLE;
      jumbo            <= 1'b0;
      jumbo_in_pending <= 1'b0;
    end else begin
      if (state == IDLE && can_send) begin
        state <= SEND;
        jumbo <= complete_pkts == '0;
      end else if (state == SEND && m_eop) begin
        state <= IDLE;
        jumbo <= 1'b0;
      end
      jumbo_in_pending <= go_jumbo ? 1'b1 : (s_hs && s_tlast) ? 1'b0 : jumbo_in_pending;
    end
endmodule

// File: tb/tb_axis_pkt_shaper.sv
// tb_axis_pkt_shaper: table-driven and scoreboard checks for axis_pkt_shaper
// (DEPTH 64, MAX_PKTS 2).
module tb_axis_pkt_shaper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] s_tdata, m_tdata;
  logic s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast, pkt_credit_ret, credit_err;
  logic [7:0] pkts_outstanding;
  int checks = 0;
  int errors = 0;
  logic [32:0] src_q[$], exp_q[$], got_q[$];
  int acc_cnt, full_at, model_out;
  bit saw_full, rnd_ready, rnd_valid;
  logic mr_fixed;

  typedef struct {
    logic sv; logic [31:0] sd; logic sl; logic cr;
    logic ev; logic [31:0] ed; logic el; logic [7:0] ep; logic ece;
  } vec_t;
  vec_t vt[15];

  axis_pkt_shaper #(.DATA_WIDTH(32), .DEPTH(64), .MAX_PKTS(2)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .pkt_credit_ret(pkt_credit_ret), .pkts_outstanding(pkts_outstanding), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  function automatic vec_t mk(logic sv, logic [31:0] sd, logic sl, logic cr,
                              logic ev, logic [31:0] ed, logic el, logic [7:0] ep, logic ece);
    vec_t v;
    v = '{sv, sd, sl, cr, ev, ed, el, ep, ece};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0; pkt_credit_ret = 1'b0;
    @(posedge clk); #1;
    chk("rst s_tready", 64'(s_tready), 64'd0);
    chk("rst m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst pkts_outstanding", 64'(pkts_outstanding), 64'd0);
    chk("rst credit_err", 64'(credit_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    src_q.delete(); exp_q.delete(); got_q.delete();
    acc_cnt = 0; full_at = -1; model_out = 0; saw_full = 1'b0;
    rnd_ready = 1'b0; rnd_valid = 1'b0; mr_fixed = 1'b1;
  endtask

  // One clock: drive at posedge+1, observe handshakes at negedge.
  task automatic tick(input bit cr);
    s_tvalid = src_q.size() != 0 && (!rnd_valid || $urandom_range(1, 0) == 1);
    {s_tlast, s_tdata} = src_q.size() != 0 ? src_q[0] : 33'd0;
    m_tready = rnd_ready ? ($urandom_range(3, 0) != 0) : mr_fixed;
    pkt_credit_ret = cr;
    @(negedge clk);
    if (s_tvalid && s_tready) begin
      acc_cnt++;
      exp_q.push_back(src_q.pop_front());
    end else if (s_tvalid && !saw_full) begin
      saw_full = 1'b1;
      full_at = acc_cnt;
    end
    if (cr && model_out != 0) model_out--;
    if (m_tvalid && m_tready) begin
      got_q.push_back({m_tlast, m_tdata});
      if (m_tlast) model_out++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vt[0]  = mk(1'b1, 32'hA0000000, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'd0, 1'b0);
    vt[1]  = mk(1'b1, 32'hA0000001, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'd0, 1'b0);
    vt[2]  = mk(1'b1, 32'hA0000002, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'd0, 1'b0);
    vt[3]  = mk(1'b1, 32'hA0000003, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 8'd0, 1'b0);
    vt[4]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'd0, 1'b0);
    vt[5]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA0000000, 1'b0, 8'd0, 1'b0);
    vt[6]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA0000001, 1'b0, 8'd0, 1'b0);
    vt[7]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA0000002, 1'b0, 8'd0, 1'b0);
    vt[8]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA0000003, 1'b1, 8'd0, 1'b0);
    vt[9]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'd1, 1'b0);
    vt[10] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 8'd1, 1'b0);
    vt[11] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'd0, 1'b0);
    vt[12] = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 8'd0, 1'b0);
    vt[13] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'd0, 1'b1);
    vt[14] = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'd0, 1'b1);

    // 4-flit packet latency/order, then credit return and sticky credit error
    do_reset();
    for (int i = 0; i < 15; i++) begin
      s_tvalid = vt[i].sv; s_tdata = vt[i].sd; s_tlast = vt[i].sl;
      m_tready = 1'b1; pkt_credit_ret = vt[i].cr;
      @(negedge clk);
      chk($sformatf("v%0d m_tvalid", i), 64'(m_tvalid), 64'(vt[i].ev));
      chk($sformatf("v%0d s_tready", i), 64'(s_tready), 64'd1);
      chk($sformatf("v%0d pkts_outstanding", i), 64'(pkts_outstanding), 64'(vt[i].ep));
      chk($sformatf("v%0d credit_err", i), 64'(credit_err), 64'(vt[i].ece));
      if (vt[i].ev) begin
        chk($sformatf("v%0d m_tdata", i), 64'(m_tdata), 64'(vt[i].ed));
        chk($sformatf("v%0d m_tlast", i), 64'(m_tlast), 64'(vt[i].el));
      end
      @(posedge clk); #1;
    end

    // credit limit: three 1-flit packets, only two released until a credit returns
    do_reset();
    for (int i = 0; i < 3; i++) src_q.push_back({1'b1, 32'hB0 + 32'(i)});
    repeat (20) tick(1'b0);
    chk("limit count", 64'(got_q.size()), 64'd2);
    chk("limit pkts_outstanding", 64'(pkts_outstanding), 64'd2);
    chk("limit m_tvalid held", 64'(m_tvalid), 64'd0);
    if (got_q.size() >= 2) begin
      chk("limit first", 64'(got_q[0]), 64'({1'b1, 32'hB0}));
      chk("limit second", 64'(got_q[1]), 64'({1'b1, 32'hB1}));
    end
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    chk("credit release count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) chk("credit release third", 64'(got_q[2]), 64'({1'b1, 32'hB2}));
    chk("credit release pkts_outstanding", 64'(pkts_outstanding), 64'd2);

    // jumbo: 100-flit packet through a 64-entry buffer
    do_reset();
    for (int i = 0; i < 100; i++) src_q.push_back({i == 99, 32'h1000 + 32'(i)});
    for (int c = 0; c < 400 && got_q.size() < 100; c++) tick(1'b0);
    chk("jumbo full at", 64'(full_at), 64'd64);
    chk("jumbo count", 64'(got_q.size()), 64'd100);
    for (int i = 0; i < got_q.size() && i < 100; i++)
      chk($sformatf("jumbo flit %0d", i), 64'(got_q[i]), 64'({i == 99, 32'h1000 + 32'(i)}));
    chk("jumbo pkts_outstanding", 64'(pkts_outstanding), 64'd1);
    repeat (5) tick(1'b0);
    chk("jumbo idle m_tvalid", 64'(m_tvalid), 64'd0);
    src_q.push_back({1'b1, 32'h5A5A});
    tick(1'b0);
    chk("post-jumbo latency 1", 64'(m_tvalid), 64'd0);
    tick(1'b0);
    chk("post-jumbo latency 2", 64'(m_tvalid), 64'd1);
    chk("post-jumbo m_tdata", 64'(m_tdata), 64'h5A5A);

    // full-buffer stall, then random release with scoreboard
    do_reset();
    mr_fixed = 1'b0;
    for (int i = 0; i < 90; i++) src_q.push_back({i == 19 || i == 49 || i == 89, 32'h2000 + 32'(i)});
    for (int c = 0; c < 200 && !saw_full; c++) tick(1'b0);
    chk("stall full at", 64'(full_at), 64'd64);
    repeat (3) tick(1'b0);
    chk("stall s_tready", 64'(s_tready), 64'd0);
    chk("stall m_tvalid", 64'(m_tvalid), 64'd1);
    chk("stall accepted", 64'(exp_q.size()), 64'd64);
    rnd_ready = 1'b1; rnd_valid = 1'b1;
    for (int c = 0; c < 3000 && got_q.size() < 90; c++) tick(model_out != 0 && $urandom_range(1, 0) == 1);
    rnd_ready = 1'b0; rnd_valid = 1'b0; mr_fixed = 1'b1;
    chk("random accepted", 64'(exp_q.size()), 64'd90);
    chk("random delivered", 64'(got_q.size()), 64'd90);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("random flit %0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    chk("random pkts_outstanding", 64'(pkts_outstanding), 64'(model_out));
    for (int c = 0; c < 4; c++) tick(model_out != 0);
    chk("random drained pkts_outstanding", 64'(pkts_outstanding), 64'd0);
    chk("random credit_err", 64'(credit_err), 64'd0);

    // output tlast and credit return in the same cycle
    do_reset();
    src_q.push_back({1'b1, 32'hC0});
    repeat (6) tick(1'b0);
    chk("simul setup pkts_outstanding", 64'(pkts_outstanding), 64'd1);
    src_q.push_back({1'b1, 32'hC1});
    tick(1'b0);
    tick(1'b0);
    chk("simul m_tvalid", 64'(m_tvalid), 64'd1);
    tick(1'b1);
    chk("simul delivered", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) chk("simul flit", 64'(got_q[1]), 64'({1'b1, 32'hC1}));
    chk("simul pkts_outstanding", 64'(pkts_outstanding), 64'd1);
    chk("simul credit_err", 64'(credit_err), 64'd0);

    // asynchronous reset mid-packet, then a clean packet
    do_reset();
    mr_fixed = 1'b0;
    src_q.push_back({1'b1, 32'hD0});
    src_q.push_back({1'b0, 32'hD1});
    src_q.push_back({1'b0, 32'hD2});
    repeat (6) tick(1'b0);
    chk("midrst pre m_tvalid", 64'(m_tvalid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst s_tready", 64'(s_tready), 64'd0);
    chk("midrst m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst m_tdata", 64'(m_tdata), 64'd0);
    chk("midrst m_tlast", 64'(m_tlast), 64'd0);
    chk("midrst pkts_outstanding", 64'(pkts_outstanding), 64'd0);
    do_reset();
    src_q.push_back({1'b0, 32'hE0});
    src_q.push_back({1'b1, 32'hE1});
    repeat (10) tick(1'b0);
    chk("postrst count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      chk("postrst flit 0", 64'(got_q[0]), 64'({1'b0, 32'hE0}));
      chk("postrst flit 1", 64'(got_q[1]), 64'({1'b1, 32'hE1}));
    end
    chk("postrst pkts_outstanding", 64'(pkts_outstanding), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
